// File: rtl/i2c_read_word.sv
// i2c_read_word: I2C receiver that assembles 1..DATA_W bits per word and flags START, STOP and bus errors.
// Optional SCL/SDA spike filter is built in when I2C_READ_SPIKE_FILTER_EN is defined.
module i2c_read_word #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int FILT_CYC  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en,
    input  logic [$clog2(DATA_W+1)-1:0]   rd_len,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          rd_ld,
    output logic                          rd_finish,
    output logic                          get_start,
    output logic                          get_stop,
    output logic                          bus_err,
    output logic                          busy
);

    // state   | meaning
    // S_IDLE  | disabled, bit count and shift register held clear
    // S_ARMED | waiting for an SCL rising edge
    // S_HIGH  | SCL high, bit sampled, watching for START/STOP or the falling edge
    localparam int LW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIGH} state_t;

    if (DATA_W < 1 || FILT_CYC < 1) begin : g_param_check
        $error("i2c_read_word: DATA_W and FILT_CYC must be >= 1");
    end

    logic scl;
    logic sda;

`ifdef I2C_READ_SPIKE_FILTER_EN
    localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    logic [1:0]    raw;
    logic [1:0]    filt_q;
    logic [FW-1:0] fcnt_q [2];

    assign raw = {scl_i, sda_i};

    // Down-counter per line: the filtered value follows only after FILT_CYC differing clks in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= FW'(FILT_CYC - 1);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    fcnt_q[i] <= FW'(FILT_CYC - 1);
                end else if (fcnt_q[i] == '0) begin
                    filt_q[i] <= raw[i];
                    fcnt_q[i] <= FW'(FILT_CYC - 1);
                end else begin
                    fcnt_q[i] <= fcnt_q[i] - FW'(1);
                end
            end
        end
    end

    assign scl = filt_q[1];
    assign sda = filt_q[0];
`else
    assign scl = scl_i;
    assign sda = sda_i;
`endif

    state_t            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]     cnt_inc;
    logic [DATA_W-1:0] sh_q, sh_d, sh_acc;
    logic [DATA_W-1:0] data_q, data_d;
    logic              samp_q, samp_d;
    logic              disc_q, disc_d;
    logic              scl_last_q;
    logic              rd_ld_d, rd_finish_d, get_start_d, get_stop_d, bus_err_d, busy_d;
    logic              rd_ld_q, rd_finish_q, get_start_q, get_stop_q, bus_err_q, busy_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        data_d      = data_q;
        samp_d      = samp_q;
        disc_d      = disc_q;
        rd_ld_d     = 1'b0;
        rd_finish_d = 1'b0;
        get_start_d = 1'b0;
        get_stop_d  = 1'b0;
        bus_err_d   = 1'b0;
        cnt_inc     = bit_cnt_q + LW'(1);

        if (MSB_FIRST != 0) sh_acc = (sh_q << 1) | DATA_W'(samp_q);
        else                sh_acc = sh_q | (DATA_W'(samp_q) << bit_cnt_q);

        if (!rd_en) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sh_d      = '0;
            disc_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                    len_d   = (rd_len == '0 || rd_len > LW'(DATA_W)) ? LW'(DATA_W) : rd_len;
                end
                S_ARMED: begin
                    if (!scl_last_q && scl) begin
                        state_d = S_HIGH;
                        samp_d  = sda;
                        disc_d  = 1'b0;
                    end
                end
                S_HIGH: begin
                    if (scl_last_q && !scl) begin
                        state_d = S_ARMED;
                        if (!disc_q) begin
                            rd_ld_d = 1'b1;
                            if (cnt_inc == len_q) begin
                                data_d      = sh_acc;
                                rd_finish_d = 1'b1;
                                bit_cnt_d   = '0;
                                sh_d        = '0;
                            end else begin
                                bit_cnt_d = cnt_inc;
                                sh_d      = sh_acc;
                            end
                        end
                    end else if (scl_last_q && scl && (sda != samp_q)) begin
                        // SDA moved under a stable-high SCL: START/STOP, the current bit is dropped.
                        samp_d      = sda;
                        disc_d      = 1'b1;
                        get_start_d = !sda;
                        get_stop_d  = sda;
                        if (!(bit_cnt_q == '0 && len_q > LW'(1))) begin
                            bus_err_d = 1'b1;
                            bit_cnt_d = '0;
                            sh_d      = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (bit_cnt_d != '0) || (state_d == S_HIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= LW'(DATA_W);
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            samp_q      <= 1'b1;
            disc_q      <= 1'b0;
            scl_last_q  <= 1'b1;
            rd_ld_q     <= 1'b0;
            rd_finish_q <= 1'b0;
            get_start_q <= 1'b0;
            get_stop_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            data_q      <= data_d;
            samp_q      <= samp_d;
            disc_q      <= disc_d;
            scl_last_q  <= scl;
            rd_ld_q     <= rd_ld_d;
            rd_finish_q <= rd_finish_d;
            get_start_q <= get_start_d;
            get_stop_q  <= get_stop_d;
            bus_err_q   <= bus_err_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o    = data_q;
    assign rd_ld     = rd_ld_q;
    assign rd_finish = rd_finish_q;
    assign get_start = get_start_q;
    assign get_stop  = get_stop_q;
    assign bus_err   = bus_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_read_word.sv
// tb_i2c_read_word: drives an MSB-first 8-bit and an LSB-first 12-bit receiver from one bus and
// checks both against a word-level model of the receive rules.
module tb_i2c_read_word;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_len = 4'd0;
    logic        scl = 1'b0;
    logic        sda = 1'b1;
    logic [7:0]  data_a;
    logic [11:0] data_b;
    logic [1:0]  ld, fin, st, sp, er, bz;

    int n_tests = 0;
    int n_fail  = 0;

    int n_ld[2], n_fin[2], n_st[2], n_sp[2], n_er[2], n_bad[2];
    int e_ld[2], e_fin[2], e_st[2], e_sp[2], e_er[2];
    int m_len[2], m_cnt[2], m_word[2], m_data[2];

    always #5 clk = ~clk;

    i2c_read_word #(.DATA_W(8), .MSB_FIRST(1), .FILT_CYC(3)) u_dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_len(rd_len), .scl_i(scl), .sda_i(sda),
        .data_o(data_a), .rd_ld(ld[0]), .rd_finish(fin[0]), .get_start(st[0]),
        .get_stop(sp[0]), .bus_err(er[0]), .busy(bz[0]));

    i2c_read_word #(.DATA_W(12), .MSB_FIRST(0), .FILT_CYC(3)) u_dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_len(rd_len), .scl_i(scl), .sda_i(sda),
        .data_o(data_b), .rd_ld(ld[1]), .rd_finish(fin[1]), .get_start(st[1]),
        .get_stop(sp[1]), .bus_err(er[1]), .busy(bz[1]));

    initial begin
        for (int i = 0; i < 2; i++) begin
            n_ld[i] = 0; n_fin[i] = 0; n_st[i] = 0; n_sp[i] = 0; n_er[i] = 0; n_bad[i] = 0;
            e_ld[i] = 0; e_fin[i] = 0; e_st[i] = 0; e_sp[i] = 0; e_er[i] = 0;
            m_len[i] = 0; m_cnt[i] = 0; m_word[i] = 0; m_data[i] = 0;
        end
    end

    // Pulse counters; a finish without a bit load or an error without START/STOP is counted as bad.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ld[i])  n_ld[i]  <= n_ld[i] + 1;
            if (fin[i]) n_fin[i] <= n_fin[i] + 1;
            if (st[i])  n_st[i]  <= n_st[i] + 1;
            if (sp[i])  n_sp[i]  <= n_sp[i] + 1;
            if (er[i])  n_er[i]  <= n_er[i] + 1;
            if ((fin[i] && !ld[i]) || (er[i] && !(st[i] || sp[i])) || (st[i] && sp[i]))
                n_bad[i] <= n_bad[i] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dw(input int i);
        return (i == 0) ? 8 : 12;
    endfunction

    function automatic bit msb_first(input int i);
        return (i == 0);
    endfunction

    task automatic m_abort();
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_word[i] = 0; end
    endtask

    task automatic m_enable(input int rl);
        for (int i = 0; i < 2; i++) begin
            m_len[i]  = (rl == 0 || rl > dw(i)) ? dw(i) : rl;
            m_cnt[i]  = 0;
            m_word[i] = 0;
        end
    endtask

    task automatic m_bit(input int b);
        for (int i = 0; i < 2; i++) begin
            e_ld[i]++;
            if (msb_first(i)) m_word[i] = m_word[i] * 2 + b;
            else              m_word[i] = m_word[i] + (b << m_cnt[i]);
            m_cnt[i]++;
            if (m_cnt[i] == m_len[i]) begin
                m_data[i] = m_word[i];
                e_fin[i]++;
                m_cnt[i]  = 0;
                m_word[i] = 0;
            end
        end
    endtask

    task automatic m_event(input int nb);
        for (int i = 0; i < 2; i++) begin
            if (nb == 0) e_st[i]++;
            else         e_sp[i]++;
            if (!(m_cnt[i] == 0 && m_len[i] > 1)) begin
                e_er[i]++;
                m_cnt[i]  = 0;
                m_word[i] = 0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        sda = b; tick(4); scl = 1'b1; tick(4); scl = 1'b0; tick(5);
        m_bit(b);
    endtask

    task automatic send_event(input bit b);
        sda = b; tick(4); scl = 1'b1; tick(4); sda = !b; tick(4); scl = 1'b0; tick(5);
        m_event(!b);
    endtask

    task automatic send_sim(input bit b);
        sda = !b; tick(4); scl = 1'b1; sda = b; tick(4); scl = 1'b0; sda = !b; tick(5);
        m_bit(b);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) send_bit(v[k]);
    endtask

    task automatic enable(input logic [3:0] rl);
        rd_en = 1'b0; tick(2); m_abort();
        rd_len = rl; rd_en = 1'b1; tick(2);
        rd_len = 4'($urandom);
        m_enable(rl);
    endtask

    task automatic abort();
        rd_en = 1'b0; tick(2); m_abort();
    endtask

    task automatic check_all(input string tag);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_ld%0d", tag, i),    n_ld[i],  e_ld[i]);
            check_val($sformatf("%s_fin%0d", tag, i),   n_fin[i], e_fin[i]);
            check_val($sformatf("%s_start%0d", tag, i), n_st[i],  e_st[i]);
            check_val($sformatf("%s_stop%0d", tag, i),  n_sp[i],  e_sp[i]);
            check_val($sformatf("%s_err%0d", tag, i),   n_er[i],  e_er[i]);
            check_val($sformatf("%s_pair%0d", tag, i),  n_bad[i], 0);
            check_val($sformatf("%s_busy%0d", tag, i),  bz[i],    (m_cnt[i] != 0));
        end
        check_val({tag, "_data_a"}, data_a, m_data[0]);
        check_val({tag, "_data_b"}, data_b, m_data[1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3); #1;
        check_val("rst_data_a", data_a, 0);
        check_val("rst_data_b", data_b, 0);
        check_val("rst_pulses", {ld, fin, st, sp, er}, 0);
        check_val("rst_busy", bz, 0);
        rst = 1'b0;
        tick(2);

        enable(4'd8);
        send_bits(32'b10100101, 8);
        check_all("a5");
        check_val("a5_const", data_a, 32'hA5);

        enable(4'd3);
        send_bits(32'b110, 3);
        check_all("len3_w1");
        check_val("len3_w1_const", data_a, 32'h06);
        send_bits(32'b011, 3);
        check_all("len3_w2");
        check_val("len3_w2_const", data_a, 32'h03);

        enable(4'd1);
        send_bit(1'b0);
        check_all("ack");
        send_event(1'b1);
        check_all("ack_start");

        enable(4'd8);
        send_event(1'b1);
        check_all("start_legal");
        send_bits(32'b1011, 4);
        send_event(1'b1);
        check_all("start_mid");
        check_val("start_mid_busy", bz[0], 0);
        send_bits(32'b11001010, 8);
        check_all("after_err");
        send_event(1'b0);
        check_all("stop_legal");

        send_bits(32'b10110, 5);
        abort();
        check_all("abort");
        enable(4'd8);
        send_bits(32'b00111100, 8);
        check_all("reenable");

        send_sim(1'b1);
        send_sim(1'b0);
        check_all("simul");
        abort();

        scl = 1'b1; tick(6);
        rd_len = 4'd8; rd_en = 1'b1; m_enable(8); tick(6);
        scl = 1'b0; tick(6);
        check_all("midhigh");

        for (int it = 0; it < 24; it++) begin
            enable(4'($urandom_range(0, 15)));
            for (int k = 0; k < int'($urandom_range(1, 30)); k++) begin
                case ($urandom_range(0, 19))
                    0:       send_event(1'($urandom_range(0, 1)));
                    1:       send_sim(1'($urandom_range(0, 1)));
                    default: send_bit(1'($urandom_range(0, 1)));
                endcase
            end
            if ($urandom_range(0, 3) == 0) abort();
            check_all($sformatf("rand%0d", it));
        end

`ifdef I2C_READ_SPIKE_FILTER_EN
        enable(4'd8);
        scl = 1'b1; tick(2); scl = 1'b0; tick(8);
        check_all("glitch");
        send_bit(1'b1);
        check_all("wide_pulse");
`endif

        enable(4'd8);
        send_bits(32'b101, 3);
        sda = 1'b1; tick(4); scl = 1'b1; tick(2);
        rst = 1'b1; rd_en = 1'b0; tick(2); #1;
        for (int i = 0; i < 2; i++) begin m_data[i] = 0; m_cnt[i] = 0; m_word[i] = 0; end
        check_val("rst_mid_busy", bz, 0);
        check_val("rst_mid_data_a", data_a, 0);
        check_val("rst_mid_data_b", data_b, 0);
        scl = 1'b0; tick(2);
        rst = 1'b0; tick(6);
        enable(4'd5);
        send_bits(32'b10011, 5);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
